// File: rtl/led_serial_driver.sv
// Serial LED / 7-segment chain driver: valid/ready word in, divided led_clk/led_do out, led_pen latch.
// Optional auto-refresh of the last word is compiled in with `define LED_REFRESH_EN.
module led_serial_driver #(
    parameter int DATA_W      = 16,
    parameter int DIV         = 4,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int REFRESH_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              led_clk,
    output logic              led_do,
    output logic              led_clr,
    output logic              led_pen
);

    localparam int PER = 2 * DIV;
    localparam int CW  = $clog2(PER);
    localparam int BW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] PER_LAST = CW'(PER - 1);
    localparam logic [CW-1:0] HALF     = CW'(DIV);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_CLR,
        S_IDLE,
        S_SHIFT,
        S_LATCH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]     r_cnt;
    logic [BW-1:0]     r_bit;
    logic [DATA_W-1:0] r_sr;
    logic              r_do;
    logic              r_done;

    logic              w_hs;
    logic              w_refresh;
    logic              w_start;
    logic              w_per_end;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] w_sr_adv;
    logic              w_first_ld;
    logic              w_first_adv;

    assign w_hs      = (r_state == S_IDLE) && din_valid;
    assign w_start   = w_hs || w_refresh;
    assign w_per_end = (r_cnt == PER_LAST);

`ifdef LED_REFRESH_EN
    localparam int IW = $clog2(REFRESH_CYC + 1);

    logic [IW-1:0]     r_idle;
    logic [DATA_W-1:0] r_last;

    // a same-cycle handshake beats the refresh
    assign w_refresh = (r_state == S_IDLE) && !din_valid
                     && (r_idle == IW'(REFRESH_CYC - 1));
    assign w_word    = w_hs ? din : r_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idle <= '0;
            r_last <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_start) begin
                    r_idle <= '0;
                end else begin
                    r_idle <= r_idle + 1'b1;
                end
            end
            if (w_hs) begin
                r_last <= din;
            end
        end
    end
`else
    logic w_unused_refresh;

    assign w_unused_refresh = (REFRESH_CYC > 0);
    assign w_refresh        = 1'b0;
    assign w_word           = din;
`endif

    assign w_sr_adv    = MSB_FIRST ? (r_sr << 1) : (r_sr >> 1);
    assign w_first_ld  = MSB_FIRST ? w_word[DATA_W-1] : w_word[0];
    assign w_first_adv = MSB_FIRST ? w_sr_adv[DATA_W-1] : w_sr_adv[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_CLR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_CLR:   if (w_per_end) w_next = S_IDLE;
            S_IDLE:  if (w_start) w_next = S_SHIFT;
            S_SHIFT: if (w_per_end && (r_bit == BIT_LAST)) w_next = S_LATCH;
            S_LATCH: if (w_per_end) w_next = S_IDLE;
            default: w_next = S_CLR;
        endcase
    end

    always_comb begin
        din_ready = 1'b0;
        busy      = 1'b1;
        led_clk   = 1'b0;
        led_pen   = 1'b0;
        led_clr   = 1'b1;
        unique case (r_state)
            S_CLR:   led_clr = 1'b0;
            S_IDLE: begin
                din_ready = 1'b1;
                busy      = 1'b0;
            end
            S_SHIFT: led_clk = (r_cnt >= HALF);
            S_LATCH: led_pen = 1'b1;
            default: led_clr = 1'b0;
        endcase
    end

    assign led_do     = r_do;
    assign frame_done = r_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_bit  <= '0;
            r_sr   <= '0;
            r_do   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_LATCH) && w_per_end;
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                    if (w_start) begin
                        r_sr <= w_word;
                        r_do <= w_first_ld;
                    end
                end
                S_SHIFT: begin
                    r_cnt <= w_per_end ? '0 : r_cnt + 1'b1;
                    if (w_per_end) begin
                        r_sr <= w_sr_adv;
                        // led_do keeps the final bit once the word is out
                        if (r_bit != BIT_LAST) begin
                            r_bit <= r_bit + 1'b1;
                            r_do  <= w_first_adv;
                        end else begin
                            r_bit <= '0;
                        end
                    end
                end
                default: r_cnt <= w_per_end ? '0 : r_cnt + 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_led_serial_driver.sv
// Directed bench for led_serial_driver: 16-bit MSB/LSB-first at DIV=2 plus a 1-bit DIV=1 corner.
// Refresh scenarios are exercised when LED_REFRESH_EN is defined.
module tb_led_serial_driver;

    localparam int W  = 16;
    localparam int DV = 2;
    localparam int RC = 10;

    logic         clk       = 1'b0;
    logic         reset     = 1'b0;
    logic [W-1:0] din       = '0;
    logic         din_valid = 1'b0;

    logic m_ready, m_busy, m_done, m_lclk, m_do, m_clr, m_pen;
    logic l_ready, l_busy, l_done, l_lclk, l_do, l_clr, l_pen;
    logic s_ready, s_busy, s_done, s_lclk, s_do, s_clr, s_pen;

    logic [6:0]  w_mvec;
    logic [6:0]  w_lvec;
    logic [15:0] sm;
    logic [15:0] sl;

    int n_chk = 0;
    int n_err = 0;

    assign w_mvec = {m_busy, m_ready, m_done, m_lclk, m_do, m_clr, m_pen};
    assign w_lvec = {l_busy, l_ready, l_done, l_lclk, l_do, l_clr, l_pen};

    always #5 clk = ~clk;

    led_serial_driver #(
        .DATA_W(W), .DIV(DV), .MSB_FIRST(1'b1), .REFRESH_CYC(RC)
    ) u_dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(m_ready), .busy(m_busy), .frame_done(m_done),
        .led_clk(m_lclk), .led_do(m_do), .led_clr(m_clr), .led_pen(m_pen)
    );

    led_serial_driver #(
        .DATA_W(W), .DIV(DV), .MSB_FIRST(1'b0), .REFRESH_CYC(RC)
    ) u_dut_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(l_ready), .busy(l_busy), .frame_done(l_done),
        .led_clk(l_lclk), .led_do(l_do), .led_clr(l_clr), .led_pen(l_pen)
    );

    led_serial_driver #(
        .DATA_W(1), .DIV(1), .MSB_FIRST(1'b1), .REFRESH_CYC(RC)
    ) u_dut_w1 (
        .clk(clk), .reset(reset), .din(din[0:0]), .din_valid(din_valid),
        .din_ready(s_ready), .busy(s_busy), .frame_done(s_done),
        .led_clk(s_lclk), .led_do(s_do), .led_clr(s_clr), .led_pen(s_pen)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // entered in cycle 1 after reset release; returns in cycle 5
    task automatic clr_seq();
        for (int c = 1; c <= 4; c++) begin
            check("clr_m", {m_clr, m_ready, m_busy, m_pen}, 4'b0010);
            check("clr_l", {l_clr, l_ready, l_busy}, 3'b001);
            check("clr_w1", {s_clr, s_ready, s_busy},
                  (c >= 3) ? 3'b110 : 3'b001);
            tick();
        end
        check("clr_end_m", {m_clr, m_ready, m_busy, m_pen}, 4'b1100);
        check("clr_end_l", {l_clr, l_ready, l_busy}, 3'b110);
    endtask

    // called in the handshake cycle T; returns in the frame_done cycle
    task automatic run_frame(input logic [15:0] nd, input logic nv,
                             input logic exp_first, input logic chk_w1,
                             output logic [15:0] seq_m,
                             output logic [15:0] seq_l);
        logic [3:0] sx [5] = '{4'b0100, 4'b1100, 4'b0110, 4'b0110, 4'b0101};
        int c;
        tick();
        din       = nd;
        din_valid = nv;
        check("first_bit", m_do, exp_first);
        check("ready_drop", {m_ready, m_busy, l_ready, l_busy}, 4'b0101);
        for (int k = 0; k < 16; k++) begin
            for (int p = 0; p < 4; p++) begin
                c = 1 + 4 * k + p;
                check("shift_clk", {m_lclk, m_pen, m_done, l_lclk, l_pen},
                      (p >= 2) ? 5'b10010 : 5'b00000);
                if (p == 2) begin
                    seq_m = {seq_m[14:0], m_do};
                    seq_l = {seq_l[14:0], l_do};
                end
                if (chk_w1 && c <= 5) begin
                    check("w1_frame", {s_lclk, s_do, s_pen, s_done}, sx[c-1]);
                end
                tick();
            end
        end
        for (int p = 0; p < 4; p++) begin
            check("latch_m", {m_pen, m_lclk, m_busy, m_done, m_ready}, 5'b10100);
            check("latch_l", {l_pen, l_lclk, l_busy, l_done, l_ready}, 5'b10100);
            tick();
        end
        check("frame_done_m", {m_done, m_ready, m_busy, m_pen}, 4'b1100);
        check("frame_done_l", {l_done, l_ready, l_busy, l_pen}, 4'b1100);
    endtask

    initial begin
        tick();
        tick();
        check("rst_m", w_mvec, 7'b1000000);
        check("rst_l", w_lvec, 7'b1000000);
        check("rst_w1", {s_busy, s_ready, s_done, s_lclk, s_do, s_clr, s_pen},
              7'b1000000);
        reset = 1'b1;
        clr_seq();

        din       = 16'hA5C3;
        din_valid = 1'b1;
        run_frame(16'h0F0F, 1'b0, 1'b1, 1'b1, sm, sl);
        check("seq_msb", sm, 16'hA5C3);
        check("seq_lsb", sl, 16'hC3A5);
        check("do_hold", {m_do, l_do}, 2'b11);

        din       = 16'h0001;
        din_valid = 1'b1;
        run_frame(16'hFFFF, 1'b1, 1'b0, 1'b0, sm, sl);
        check("b2b_1_msb", sm, 16'h0001);
        check("b2b_1_lsb", sl, 16'h8000);
        run_frame(16'h0000, 1'b0, 1'b1, 1'b0, sm, sl);
        check("b2b_2_msb", sm, 16'hFFFF);
        check("b2b_2_lsb", sl, 16'hFFFF);

`ifdef LED_REFRESH_EN
        din       = 16'h1234;
        din_valid = 1'b1;
        run_frame(16'h0000, 1'b0, 1'b0, 1'b0, sm, sl);
        check("word_1234", sm, 16'h1234);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("refresh_wait", {m_busy, m_ready, m_pen}, 3'b010);
        end
        run_frame(16'h0000, 1'b0, 1'b0, 1'b0, sm, sl);
        check("refresh_msb", sm, 16'h1234);
        check("refresh_lsb", sl, 16'h2C48);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("expiry_wait", {m_busy, m_ready, m_pen}, 3'b010);
        end
        din       = 16'h5A3C;
        din_valid = 1'b1;
        run_frame(16'h0000, 1'b0, 1'b0, 1'b0, sm, sl);
        check("expiry_wins", sm, 16'h5A3C);
`else
        for (int i = 0; i < 30; i++) begin
            tick();
            check("idle_quiet", {m_busy, m_ready, m_pen, m_done, m_lclk},
                  5'b01000);
        end
`endif

        din       = 16'hA5C3;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (28) tick();
        check("abort_busy", {m_busy, m_lclk, m_pen}, 3'b100);
        #2;
        reset = 1'b0;
        #1;
        check("abort_async_m", w_mvec, 7'b1000000);
        check("abort_async_l", w_lvec, 7'b1000000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_hold", w_mvec, 7'b1000000);
        end
        reset = 1'b1;
        clr_seq();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_abort", {m_busy, m_ready, m_pen, m_done}, 4'b0100);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/led_serial_driver.md
Name: led_serial_driver

Overview:
- Parametrised next-generation serial LED/7-segment display driver.
- Accepts a DATA_W-bit display word through a valid/ready handshake.
- Shifts the word out on a divided serial clock (led_clk/led_do), then pulses led_pen to latch the external shift-register chain.
- Sits between datapath result logic (adder sums, register/PC debug values) and the board LED interface. Adds a handshake, configurable width/rate/bit order, and frame-complete signalling.

Parameters:
- DATA_W, 16, serial word width in bits; legal range 1..64.
- DIV, 4, led_clk half-period in clk cycles; must be >= 1.
- MSB_FIRST, 1, bit order: 1 = din[DATA_W-1] shifted first, 0 = din[0] shifted first.
- REFRESH_CYC, 1024, idle clk cycles before auto-refresh. Used only when LED_REFRESH_EN is defined.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- din, input, DATA_W, display word.
- din_valid, input, 1, din holds a valid word.
- din_ready, output, 1, driver can accept a word.
- busy, output, 1, high whenever the FSM is not in IDLE.
- frame_done, output, 1, one-cycle pulse when a frame has been fully latched.
- led_clk, output, 1, serial shift clock.
- led_do, output, 1, serial data; stable across each led_clk rising edge.
- led_clr, output, 1, active-low clear of the external chain.
- led_pen, output, 1, parallel latch enable, active high.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: led_clk=0, led_do=0, led_clr=0, led_pen=0, din_ready=0, busy=1, frame_done=0.
  - Internal state: shift register=0, counters=0.
  - FSM forced to CLR.
- FSM states are CLR, IDLE, SHIFT, LATCH.
- CLR:
  - led_clr=0 for 2*DIV cycles after reset release, then led_clr=1 and go to IDLE.
  - led_clr stays 1 until the next reset.
- IDLE:
  - Outputs: din_ready=1, busy=0, led_clk=0, led_pen=0; led_do holds its last value.
  - Handshake: transfer occurs on a rising edge with din_valid=1 and din_ready=1 (cycle T).
  - At T, din is captured and the FSM goes to SHIFT. din_ready=0 from T+1.
- SHIFT:
  - DATA_W bit periods, each 2*DIV cycles.
  - Within a bit period, led_clk=0 for the first DIV cycles and 1 for the last DIV cycles.
  - led_do presents the current bit for the whole period.
  - The first bit is on led_do from cycle T+1.
  - The shifter advances at the end of each period.
- LATCH:
  - Starts at cycle T+1+2*DIV*DATA_W.
  - Outputs: led_clk=0, led_pen=1 for 2*DIV cycles.
  - Then led_pen=0, frame_done=1 for one cycle, FSM to IDLE, din_ready=1 in that same cycle.
  - The frame_done cycle is T+1+2*DIV*(DATA_W+1).
  - A new handshake may occur in the frame_done cycle, giving back-to-back frames.
- din_valid while busy: ignored; no capture, no queuing. The source must hold din_valid until it sees ready.
- din changing after capture does not affect the frame in flight.
- Reset mid-frame: the frame is aborted immediately (no led_pen pulse, no frame_done) and the CLR sequence repeats.
- Counter widths: $clog2 sized. The bit counter wraps only by FSM exit, never modulo.
- DATA_W=1: exactly one bit period, then LATCH.

Optional Feature:
- Macro: LED_REFRESH_EN.
- Defined:
  - An idle counter increments each IDLE cycle with no handshake.
  - When it reaches REFRESH_CYC, the last captured word is re-shifted and re-latched: full SHIFT + LATCH, frame_done pulses, din_ready=0 during the refresh.
  - The counter clears on any handshake or refresh start.
  - A handshake in the same cycle the count expires wins; the new word is sent and the refresh is skipped.
  - Before any word has been captured after reset, the refresh sends all zeros.
- Undefined: IDLE persists indefinitely with no spontaneous activity. REFRESH_CYC has no effect and no counter logic is generated.

Test Plan:
- Reset release, DIV=2: led_clr=0 for 4 cycles, then 1; din_ready rises in cycle 5; led_pen never pulses.
- DATA_W=16, DIV=2, MSB_FIRST=1, din=16'hA5C3 accepted at T:
  - led_do sampled at the 16 led_clk rising edges = 1010_0101_1100_0011.
  - led_pen high for cycles T+65..T+68.
  - frame_done pulses at T+69.
- Same word with MSB_FIRST=0: sampled bits = 1100_0011_1010_0101 (din[0] first).
- din_valid held high with two words (16'h0001 then 16'hFFFF):
  - Second handshake occurs in the first frame_done cycle.
  - Second frame's led_do=1 from the next cycle.
  - No gap or dropped word.
- Reset asserted at SHIFT bit 7: all outputs go to reset values asynchronously; no frame_done; the CLR sequence repeats after release.
- With LED_REFRESH_EN, REFRESH_CYC=10:
  - After one frame of 16'h1234, an automatic identical frame starts 10 idle cycles after frame_done.
  - A din_valid asserted on the expiry cycle sends the new word instead.
